mem_bus_arbiter: RTL and testbench

- Shares one unified single-port memory bus between the CPU instruction-fetch port and the load/store data port.
- Each port uses a req/ack handshake. The arbiter picks one requester round-robin, runs one memory transaction with wait-state support, then returns read data and an ack pulse.
- A bus-timeout counter aborts transactions the memory never completes, and reports them as errors.
- Sits between the Cpu memory ports and the memory/peripheral fabric. The ack pulses serve as the CPU's fetch/data stall-release signals.

---
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch and data ports; req to ack is 2 cycles plus memory wait states.
// Requests are held until ack; a bus timeout aborts stalled cycles with an error ack.
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LIM = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_d_q, last_d_d;
    logic              if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DW-1:0]     if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic if_eff, d_eff, gnt_if, gnt_d;
    logic [DW-1:0] rdata_sel;

    // A port whose ack is showing this cycle has already been served.
    assign if_eff = if_req & ~if_ack_q;
    assign d_eff  = d_req & ~d_ack_q;
    assign gnt_if = if_eff & (~d_eff | last_d_q);
    assign gnt_d  = d_eff & ~gnt_if;
    assign rdata_sel = mem_we_q ? '0 : mem_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        unique case (state_q)
            IDLE, RESP: begin
                cnt_d     = '0;
                mem_req_d = 1'b0;
                state_d   = IDLE;
                if (gnt_if) begin
                    state_d     = BUSY_IF;
                    last_d_d    = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end else if (gnt_d) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_we ? d_wstrb : '0;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ready || (TIMEOUT != 0 && cnt_q == TO_LIM)) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_IF) begin
                        if_ack_d   = 1'b1;
                        if_err_d   = ~mem_ready;
                        if_rdata_d = mem_ready ? rdata_sel : '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_err_d   = ~mem_ready;
                        d_rdata_d = mem_ready ? rdata_sel : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_d_q    <= 1'b1;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_d_q    <= last_d_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: latency, round-robin, wait states, timeout, reset.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int if_acks;
        int d_acks;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_acks", {30'b0, if_ack, d_ack}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // Zero-wait fetch
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h00500093;
        tick();
        chk("zw_mem_req", {31'b0, mem_req}, 32'd1);
        chk("zw_mem_addr", mem_addr, 32'h100);
        chk("zw_mem_we", {31'b0, mem_we}, 32'd0);
        chk("zw_if_ack_early", {31'b0, if_ack}, 32'd0);
        tick();
        chk("zw_if_ack", {31'b0, if_ack}, 32'd1);
        chk("zw_if_rdata", if_rdata, 32'h00500093);
        chk("zw_if_err", {31'b0, if_err}, 32'd0);
        chk("zw_mem_req_drop", {31'b0, mem_req}, 32'd0);
        if_req = 1'b0; mem_ready = 1'b0;
        tick();
        chk("zw_if_ack_pulse", {31'b0, if_ack}, 32'd0);
        chk("zw_if_rdata_hold", if_rdata, 32'h00500093);

        // Simultaneous requests after reset: fetch first, store next
        do_reset();
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b1111;
        mem_ready = 1'b1; mem_rdata = 32'h11111111;
        tick();
        chk("sim_first_addr", mem_addr, 32'h104);
        chk("sim_first_we", {31'b0, mem_we}, 32'd0);
        chk("sim_first_wstrb", {28'b0, mem_wstrb}, 32'd0);
        tick();
        chk("sim_if_ack", {31'b0, if_ack}, 32'd1);
        chk("sim_if_rdata", if_rdata, 32'h11111111);
        if_req = 1'b0;
        tick();
        chk("sim_st_req", {31'b0, mem_req}, 32'd1);
        chk("sim_st_we", {31'b0, mem_we}, 32'd1);
        chk("sim_st_addr", mem_addr, 32'h2000);
        chk("sim_st_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sim_st_wstrb", {28'b0, mem_wstrb}, 32'hF);
        tick();
        chk("sim_d_ack", {31'b0, d_ack}, 32'd1);
        chk("sim_d_rdata", d_rdata, 32'd0);
        chk("sim_d_err", {31'b0, d_err}, 32'd0);
        d_req = 1'b0;
        tick();
        chk("sim_d_ack_pulse", {31'b0, d_ack}, 32'd0);

        // Round-robin: both request for 20 cycles, zero-wait memory
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; d_wstrb = 4'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0;
        if_acks = 0; d_acks = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if_acks += int'(if_ack);
            d_acks  += int'(d_ack);
            chk($sformatf("rr_req_%0d", i), {31'b0, mem_req}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 1)
                chk($sformatf("rr_addr_%0d", i), mem_addr, (i % 4 == 1) ? 32'h400 : 32'h800);
        end
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        chk("rr_if_acks", if_acks, 32'd5);
        chk("rr_d_acks", d_acks, 32'd5);
        tick();
        chk("rr_idle", {31'b0, mem_req}, 32'd0);

        // Wait states: 3 cycles; address change after grant must not leak
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; mem_rdata = 32'h12345678;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) d_addr = 32'h3FFC;
            chk($sformatf("ws_req_%0d", i), {31'b0, mem_req}, 32'd1);
            chk($sformatf("ws_addr_%0d", i), mem_addr, 32'h3000);
            chk($sformatf("ws_noack_%0d", i), {31'b0, d_ack}, 32'd0);
        end
        mem_ready = 1'b1;
        tick();
        chk("ws_d_ack", {31'b0, d_ack}, 32'd1);
        chk("ws_d_rdata", d_rdata, 32'h12345678);
        chk("ws_d_err", {31'b0, d_err}, 32'd0);
        chk("ws_req_drop", {31'b0, mem_req}, 32'd0);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Timeout: memory never answers
        d_req = 1'b1; d_addr = 32'h5000;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1 || i == 16)
                chk($sformatf("to_req_%0d", i), {31'b0, mem_req}, 32'd1);
            if (i == 15)
                chk("to_no_ack", {31'b0, d_ack}, 32'd0);
        end
        tick();
        chk("to_req_drop", {31'b0, mem_req}, 32'd0);
        chk("to_d_ack", {31'b0, d_ack}, 32'd1);
        chk("to_d_err", {31'b0, d_err}, 32'd1);
        chk("to_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        tick();
        chk("to_err_clear", {31'b0, d_err}, 32'd0);
        if_req = 1'b1; if_addr = 32'h600; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        tick();
        chk("to_fetch_ack", {31'b0, if_ack}, 32'd1);
        chk("to_fetch_err", {31'b0, if_err}, 32'd0);
        chk("to_fetch_rdata", if_rdata, 32'hCAFEF00D);
        if_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Reset mid-transaction, then pending fetch wins
        d_req = 1'b1; d_addr = 32'h7000;
        tick();
        tick();
        chk("mr_busy", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h700;
        tick();
        chk("mr_req_drop", {31'b0, mem_req}, 32'd0);
        chk("mr_no_acks", {30'b0, if_ack, d_ack}, 32'd0);
        rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hAAAA5555;
        tick();
        chk("mr_grant_if", mem_addr, 32'h700);
        tick();
        chk("mr_if_ack", {31'b0, if_ack}, 32'd1);
        if_req = 1'b0;
        tick();
        chk("mr_grant_d", mem_addr, 32'h7000);
        tick();
        chk("mr_d_ack", {31'b0, d_ack}, 32'd1);
        chk("mr_d_rdata", d_rdata, 32'hAAAA5555);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
